// File: rtl/bj_pkg.sv
// rtl/bj_pkg.sv - shared decode constants, BHT counter type and update helper
package bj_pkg;

  localparam logic [2:0] JMP_PFX = 3'b001;
  localparam logic [2:0] BR_PFX  = 3'b011;

  typedef enum logic [1:0] {
    BEQZ = 2'b00,
    BNEZ = 2'b01,
    BLTZ = 2'b10,
    BGEZ = 2'b11
  } br_mode_e;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t BHT_RESET = 2'b01;

  function automatic bht_ctr_t ctr_update(input bht_ctr_t c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'd1;
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/bj_cond_eval.sv
// rtl/bj_cond_eval.sv - opcode decode and zero/sign branch condition evaluation
module bj_cond_eval
  import bj_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [4:0]   opcode,
  input  logic [N-1:0] rs,
  output logic         is_jump,
  output logic         is_branch,
  output logic         take_branch
);

  logic cond;

  always_comb begin
    is_jump   = (opcode[4:2] == JMP_PFX);
    is_branch = (opcode[4:2] == BR_PFX);
    cond      = 1'b0;
    case (br_mode_e'(opcode[1:0]))
      BEQZ: cond = (rs == '0);
      BNEZ: cond = (rs != '0);
      BLTZ: cond = rs[N-1];
      BGEZ: cond = ~rs[N-1];
    endcase
    take_branch = is_jump | (is_branch & cond);
  end

endmodule

// File: rtl/bj_resolve_predict.sv
// rtl/bj_resolve_predict.sv - EX branch resolve, BHT predictor, mispredict redirect and perf counters
module bj_resolve_predict
  import bj_pkg::*;
#(
  parameter int N           = 16,
  parameter int PC_W        = 16,
  parameter int BHT_ENTRIES = 16,
  parameter int INST_BYTES  = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [PC_W-1:0]  f_pc,
  output logic             f_pred_taken,
  input  logic             ex_valid,
  input  logic [4:0]       ex_opcode,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic [N-1:0]     ex_rs_val,
  input  logic [PC_W-1:0]  ex_target,
  input  logic             ex_pred_taken,
  output logic             take_branch,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mp_count
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam int SH    = $clog2(INST_BYTES);
  localparam logic [PC_W-1:0] STEP = PC_W'(INST_BYTES);

  bht_ctr_t         bht [BHT_ENTRIES];
  logic             is_jump;
  logic             is_branch;
  logic             resolve;
  logic             mispredict;
  logic [IDX_W-1:0] f_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             unused_bits;

  bj_cond_eval #(.N(N)) u_cond (
    .opcode      (ex_opcode),
    .rs          (ex_rs_val),
    .is_jump     (is_jump),
    .is_branch   (is_branch),
    .take_branch (take_branch)
  );

  assign f_idx        = f_pc[IDX_W+SH-1:SH];
  assign ex_idx       = ex_pc[IDX_W+SH-1:SH];
  assign f_pred_taken = bht[f_idx][1];
  assign unused_bits  = ^{f_pc, ex_pc};

  // EX is wrong-path while a redirect is out, so it must not resolve
  assign resolve    = ex_valid & ~stall & ~redirect_valid & (is_jump | is_branch);
  assign mispredict = take_branch ^ ex_pred_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= BHT_RESET;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      br_count       <= '0;
      mp_count       <= '0;
    end else begin
      redirect_valid <= resolve & mispredict;
      if (resolve) begin
        bht[ex_idx] <= ctr_update(bht[ex_idx], take_branch);
        if (br_count != '1) br_count <= br_count + CNT_W'(1);
        // redirect_pc only moves when a redirect is actually issued
        if (mispredict) begin
          redirect_pc <= take_branch ? ex_target : ex_pc + STEP;
          if (mp_count != '1) mp_count <= mp_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bj_resolve_predict.sv
// tb/tb_bj_resolve_predict.sv - directed bench with integer-level reference model for bj_resolve_predict
module tb_bj_resolve_predict;

  localparam logic [4:0] OP_JMP  = 5'b00100;
  localparam logic [4:0] OP_BEQZ = 5'b01100;
  localparam logic [4:0] OP_BNEZ = 5'b01101;
  localparam logic [4:0] OP_BLTZ = 5'b01110;
  localparam logic [4:0] OP_BGEZ = 5'b01111;
  localparam logic [4:0] OP_ALU  = 5'b10100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [15:0] f_pc = '0;
  logic        ex_valid = 1'b0;
  logic [4:0]  ex_opcode = '0;
  logic [15:0] ex_pc = '0;
  logic [15:0] ex_rs_val = '0;
  logic [15:0] ex_target = '0;
  logic        ex_pred_taken = 1'b0;

  logic        f_pred_taken, take_branch, redirect_valid;
  logic [15:0] redirect_pc, br_count, mp_count;
  logic        f_pred_s, take_s, rv_s;
  logic [15:0] rpc_s;
  logic [3:0]  br_count_s, mp_count_s;

  int n_chk = 0;
  int n_err = 0;

  int  m_bht [16];
  bit  m_rv;
  int  m_rpc;
  int  m_br, m_mp;
  bit  started = 1'b0;

  always #5 clk = ~clk;

  bj_resolve_predict #(.N(16), .PC_W(16), .BHT_ENTRIES(16), .INST_BYTES(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_pc(ex_pc), .ex_rs_val(ex_rs_val),
    .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .take_branch(take_branch),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .br_count(br_count), .mp_count(mp_count)
  );

  bj_resolve_predict #(.N(16), .PC_W(16), .BHT_ENTRIES(16), .INST_BYTES(2), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .stall(stall), .f_pc(f_pc), .f_pred_taken(f_pred_s),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_pc(ex_pc), .ex_rs_val(ex_rs_val),
    .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .take_branch(take_s),
    .redirect_valid(rv_s), .redirect_pc(rpc_s),
    .br_count(br_count_s), .mp_count(mp_count_s)
  );

  function automatic bit ref_take(input logic [4:0] op, input logic [15:0] rs);
    if (op[4:2] == 3'b001) return 1'b1;
    if (op[4:2] != 3'b011) return 1'b0;
    case (op[1:0])
      2'd0:    return rs == 16'd0;
      2'd1:    return rs != 16'd0;
      2'd2:    return rs[15];
      default: return !rs[15];
    endcase
  endfunction

  function automatic bit ref_ctrl(input logic [4:0] op);
    return (op[4:2] == 3'b001) || (op[4:2] == 3'b011);
  endfunction

  function automatic int ref_idx(input logic [15:0] pc);
    return (int'(pc) / 2) % 16;
  endfunction

  function automatic int sat(input int v, input int w);
    int lim = (1 << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      for (int i = 0; i < 16; i++) m_bht[i] = 1;
      m_rv = 1'b0; m_rpc = 0; m_br = 0; m_mp = 0;
    end else if (ex_valid && !stall && !m_rv && ref_ctrl(ex_opcode)) begin
      bit t;
      int k;
      t = ref_take(ex_opcode, ex_rs_val);
      k = ref_idx(ex_pc);
      m_bht[k] = t ? ((m_bht[k] < 3) ? m_bht[k] + 1 : 3) : ((m_bht[k] > 0) ? m_bht[k] - 1 : 0);
      m_br++;
      m_rv = (t != ex_pred_taken);
      if (m_rv) begin
        m_mp++;
        m_rpc = t ? int'(ex_target) : (int'(ex_pc) + 2) % 65536;
      end
    end else begin
      m_rv = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("take_branch", take_branch, ref_take(ex_opcode, ex_rs_val));
      chk("f_pred_taken", f_pred_taken, m_bht[ref_idx(f_pc)] >= 2);
      chk("redirect_valid", redirect_valid, m_rv);
      chk("redirect_pc", redirect_pc, m_rpc);
      chk("br_count", br_count, sat(m_br, 16));
      chk("mp_count", mp_count, sat(m_mp, 16));
      chk("br_count_w4", br_count_s, sat(m_br, 4));
      chk("mp_count_w4", mp_count_s, sat(m_mp, 4));
    end
  end

  task automatic drive(input logic v, input logic [4:0] op, input logic [15:0] pc,
                       input logic [15:0] rs, input logic [15:0] tgt, input logic pr,
                       input logic st, input logic r, input logic [15:0] fpc);
    @(posedge clk); #2;
    ex_valid = v; ex_opcode = op; ex_pc = pc; ex_rs_val = rs; ex_target = tgt;
    ex_pred_taken = pr; stall = st; rst = r; f_pc = fpc;
  endtask

  task automatic idle(input logic [15:0] fpc, input logic st);
    drive(1'b0, 5'd0, 16'h0, 16'h0, 16'h0, 1'b0, st, 1'b0, fpc);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    idle(16'h0010, 1'b0); @(negedge clk);
    chk("reset_pred", f_pred_taken, 0);
    chk("reset_rv", redirect_valid, 0);
    chk("reset_rpc", redirect_pc, 16'h0000);
    chk("reset_br", br_count, 0);

    drive(1, OP_BEQZ, 16'h0010, 16'h0000, 16'h0040, 0, 0, 0, 16'h0010);
    idle(16'h0010, 1'b0); @(negedge clk);
    chk("beqz_rv", redirect_valid, 1);
    chk("beqz_rpc", redirect_pc, 16'h0040);
    chk("beqz_pred", f_pred_taken, 1);
    chk("beqz_br", br_count, 1);
    chk("beqz_mp", mp_count, 1);
    idle(16'h0010, 1'b0); @(negedge clk);
    chk("beqz_rv_drop", redirect_valid, 0);

    drive(1, OP_BLTZ, 16'h0000, 16'h8000, 16'h0100, 1, 0, 0, 16'h0000);
    idle(16'h0000, 1'b0); @(negedge clk);
    chk("bltz_rv", redirect_valid, 0);
    chk("bltz_pred", f_pred_taken, 1);
    drive(1, OP_BGEZ, 16'h0000, 16'h8000, 16'h0100, 0, 0, 0, 16'h0000);
    idle(16'h0000, 1'b0); @(negedge clk);
    chk("bgez_rv", redirect_valid, 0);
    chk("bgez_pred", f_pred_taken, 0);

    drive(1, OP_BNEZ, 16'h0020, 16'h0000, 16'h0080, 1, 0, 0, 16'h0020);
    idle(16'h0020, 1'b0); @(negedge clk);
    chk("bnez_rv", redirect_valid, 1);
    chk("bnez_rpc", redirect_pc, 16'h0022);
    idle(16'h0010, 1'b0);

    for (int i = 0; i < 4; i++)
      drive(1, OP_BEQZ, 16'h0010, 16'h0000, 16'h0040, 1, 0, 0, 16'h0010);
    drive(1, OP_BEQZ, 16'h0010, 16'h0001, 16'h0040, 1, 0, 0, 16'h0010);
    idle(16'h0010, 1'b0); @(negedge clk);
    chk("sat_rv", redirect_valid, 1);
    chk("sat_rpc", redirect_pc, 16'h0012);
    chk("sat_pred_10", f_pred_taken, 1);
    chk("sat_br", br_count, 9);
    drive(1, OP_BEQZ, 16'h0010, 16'h0001, 16'h0040, 1, 0, 0, 16'h0010);
    idle(16'h0010, 1'b0); @(negedge clk);
    chk("sat_pred_01", f_pred_taken, 0);
    chk("sat_mp", mp_count, 4);

    drive(1, OP_BEQZ, 16'h0030, 16'h0000, 16'h0050, 0, 0, 0, 16'h0030);
    drive(1, OP_JMP,  16'h0040, 16'h0000, 16'h0090, 0, 0, 0, 16'h0030);
    @(negedge clk);
    chk("shadow_rv", redirect_valid, 1);
    chk("shadow_rpc", redirect_pc, 16'h0050);
    idle(16'h0030, 1'b0); @(negedge clk);
    chk("shadow_rv_drop", redirect_valid, 0);
    chk("shadow_br", br_count, 11);
    chk("shadow_mp", mp_count, 5);

    drive(1, OP_BEQZ, 16'h0030, 16'h0001, 16'h0050, 1, 1, 0, 16'h0030);
    idle(16'h0030, 1'b0); @(negedge clk);
    chk("stall_rv", redirect_valid, 0);
    chk("stall_br", br_count, 11);
    chk("stall_pred", f_pred_taken, 1);

    drive(1, OP_BEQZ, 16'h0030, 16'h0001, 16'h0050, 1, 0, 0, 16'h0030);
    idle(16'h0030, 1'b1); @(negedge clk);
    chk("stall_redir_rv", redirect_valid, 1);
    chk("stall_redir_rpc", redirect_pc, 16'h0032);
    idle(16'h0030, 1'b1); @(negedge clk);
    chk("stall_redir_drop", redirect_valid, 0);

    drive(1, OP_ALU, 16'h0010, 16'h0000, 16'h0070, 1, 0, 0, 16'h0010);
    idle(16'h0010, 1'b0); @(negedge clk);
    chk("alu_br", br_count, 12);
    chk("alu_rv", redirect_valid, 0);

    drive(1, OP_JMP, 16'h0010, 16'h0000, 16'h0070, 1, 0, 0, 16'h0010);
    drive(1, OP_JMP, 16'h0010, 16'h0000, 16'h0070, 1, 0, 0, 16'h0010);
    idle(16'h0010, 1'b0); @(negedge clk);
    chk("pre_rst_pred", f_pred_taken, 1);
    drive(1, OP_JMP, 16'h0010, 16'h0000, 16'h0090, 0, 0, 1, 16'h0010);
    idle(16'h0010, 1'b0); @(negedge clk);
    chk("rst_rv", redirect_valid, 0);
    chk("rst_pred", f_pred_taken, 0);
    chk("rst_br", br_count, 0);
    chk("rst_mp", mp_count, 0);

    for (int i = 0; i < 17; i++)
      drive(1, OP_JMP, 16'(i * 2), 16'h0000, 16'h0200, 1, 0, 0, 16'h0000);
    idle(16'h0000, 1'b0); @(negedge clk);
    chk("w4_br_sat", br_count_s, 15);
    chk("w16_br", br_count, 17);
    chk("w4_mp", mp_count_s, 0);

    idle(16'h0000, 1'b0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bj_resolve_predict.md
Name: bj_resolve_predict

Overview:
- Parametrised successor to the single-cycle branch/jump decision logic.
- Resolves jumps and BEQZ/BNEZ/BLTZ/BGEZ in EX, compares the outcome with the fetch-stage prediction, and issues a registered redirect on mispredict.
- Keeps a BHT of 2-bit saturating counters that fetch reads, plus saturating branch and mispredict performance counters.
- Sits between the fetch PC mux and the EX stage.

Parameters:
- N, 16, data width of the Rs operand.
- PC_W, 16, program counter width.
- BHT_ENTRIES, 16, number of BHT counters; must be a power of 2 and at least 2. IDX_W = log2(BHT_ENTRIES).
- INST_BYTES, 2, fall-through PC increment.
- CNT_W, 16, performance counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- stall  in  1  pipeline stall; freezes resolve side
- f_pc  in  PC_W  fetch PC for BHT lookup
- f_pred_taken  out  1  prediction for f_pc
- ex_valid  in  1  EX holds a valid instruction
- ex_opcode  in  5  EX opcode
- ex_pc  in  PC_W  PC of EX instruction
- ex_rs_val  in  N  Rs operand
- ex_target  in  PC_W  taken target, computed upstream
- ex_pred_taken  in  1  prediction carried down from fetch
- take_branch  out  1  combinational resolved outcome
- redirect_valid  out  1  registered mispredict redirect
- redirect_pc  out  PC_W  registered corrected PC
- br_count  out  CNT_W  resolved control-flow ops
- mp_count  out  CNT_W  mispredicts

Behaviour:
- One clock clk. Reset rst is synchronous and active-high.
- Reset values:
  - All BHT counters = 2'b01 (weakly not-taken).
  - redirect_valid = 0, redirect_pc = 0.
  - br_count = 0, mp_count = 0.
- Reset mid-operation discards any pending redirect and reinitialises the whole BHT in the same cycle.
- Decode:
  - Jump when opcode[4:2] = 001; always taken.
  - Branch when opcode[4:2] = 011. Mode opcode[1:0]:
    - 00 BEQZ: Rs == 0
    - 01 BNEZ: Rs != 0
    - 10 BLTZ: Rs[N-1]
    - 11 BGEZ: ~Rs[N-1]
  - Any other opcode is not control flow.
- take_branch is purely combinational from ex_opcode and ex_rs_val. It is not gated by ex_valid.
- BHT index = pc[IDX_W+s-1 : s], where s = log2(INST_BYTES).
- f_pred_taken = counter[idx(f_pc)][1]. Combinational read.
- A resolve event occurs when all of the following hold: ex_valid, ~stall, ~redirect_valid, and the opcode is a jump or branch.
  - The ~redirect_valid term means the instruction in EX during a redirect cycle is wrong-path and is ignored.
- On a resolve event:
  - Clock edge, BHT: counter[idx(ex_pc)] increments when take_branch = 1 and decrements when take_branch = 0. It saturates at 11 and 00.
  - mispredict = take_branch XOR ex_pred_taken.
  - Clock edge, redirect: redirect_valid <= mispredict. redirect_pc <= ex_target if taken, else ex_pc + INST_BYTES, modulo 2^PC_W.
  - br_count increments. mp_count increments if mispredict.
  - Both performance counters saturate at all-ones.
- In any cycle without a resolve event, redirect_valid <= 0 on the next edge.
- Redirect latency is 1 cycle. redirect_valid is never high for two consecutive cycles.
- redirect_pc holds its last value when redirect_valid = 0.
- Stall while redirect_valid = 1: redirect_valid still drops after one cycle. The fetch mux must sample it in that cycle regardless of stall.
- Read/write on the same index in the same cycle: the read returns the pre-update value (read-before-write).
- Non-control-flow opcodes with ex_valid = 1 cause no BHT, counter or redirect activity.

Decomposition:
- Package bj_pkg:
  - Opcode prefix constants JMP_PFX = 3'b001 and BR_PFX = 3'b011.
  - Mode constants BEQZ/BNEZ/BLTZ/BGEZ.
  - BHT_RESET = 2'b01.
  - Typedef for the 2-bit counter.
- Sub-module bj_cond_eval (parameter N): opcode + Rs -> is_jump, is_branch, take_branch. Combinational; carries the condition equations.
- Top level holds the BHT array, redirect register and performance counters.

Test Plan:
- Reset, then f_pc = 0x0010: f_pred_taken = 0 (idx 8, counter 01).
- BEQZ at ex_pc = 0x0010, rs = 0, ex_target = 0x0040, pred 0: next cycle redirect_valid = 1, redirect_pc = 0x0040, counter[8] = 10, f_pred_taken(0x0010) = 1, br_count = 1, mp_count = 1. Following cycle redirect_valid = 0.
- Checks:
  - BNEZ at 0x0020, rs = 0, pred 1: redirect_pc = 0x0022.
  - BLTZ rs = 0x8000, pred 1: no redirect, counter[0] 01->10.
  - BGEZ rs = 0x8000, pred 0: no redirect, counter[0] 10->01.
- Four taken branches at 0x0010: counter[8] saturates at 11. Then one not-taken branch with pred 1: redirect_pc = 0x0012, counter[8] = 10.
- Wrong-path shadow:
  - Mispredicting branch, then a valid mispredicting jump on the next cycle: that jump is ignored (br_count unchanged, no second redirect).
  - Same branch with stall = 1: no update at all.
- Reset asserted the same cycle as a resolve event: next cycle redirect_valid = 0, all counters 01, br_count = mp_count = 0. With CNT_W = 4, 17 resolves: br_count = 15.
